// File: rtl/sram_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  // A 32-bit word occupies two consecutive SRAM half-words, low half first.
  function automatic logic [SRAM_ADDR_W-1:0] half_addr(input logic [16:0] word,
                                                       input logic       hi);
    return {word, hi};
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Serves one 32-bit MEM-stage load/store as two 16-bit async SRAM accesses.
// Define SRAM_RANGE_CHECK_EN to short-circuit out-of-range addresses.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  state_t                 state;
  state_t                 state_next;
  logic [3:0]             phase_cnt;
  logic                   last_phase;
  logic                   in_access;
  logic                   state_change;
  logic [31:0]            offset;
  logic [16:0]            word;
  logic                   in_range;
  logic [SRAM_DATA_W-1:0] lo_data;
  logic                   unused_low_bits;

  assign offset          = address - BASE_ADDR;
  assign word            = offset[18:2];
  assign unused_low_bits = ^offset[1:0];
  assign last_phase      = (phase_cnt == 4'(HALF_CYCLES - 1));
  assign in_access       = (state == RD_LO) || (state == RD_HI) ||
                           (state == WR_LO) || (state == WR_HI);
  assign state_change    = (state_next != state);

`ifdef SRAM_RANGE_CHECK_EN
  assign in_range = (address >= BASE_ADDR) && (offset[31:19] == 13'd0);
`else
  logic unused_high_bits;
  assign in_range         = 1'b1;
  assign unused_high_bits = ^offset[31:19];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Writes take priority when the MEM stage raises both enables.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (wr_en) begin
          state_next = in_range ? WR_LO : DONE;
        end else if (rd_en) begin
          state_next = in_range ? RD_LO : DONE;
        end
      end
      RD_LO:   if (last_phase) state_next = RD_HI;
      RD_HI:   if (last_phase) state_next = DONE;
      WR_LO:   if (last_phase) state_next = WR_HI;
      WR_HI:   if (last_phase) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt <= '0;
    end else if (state_change) begin
      phase_cnt <= '0;
    end else if (in_access) begin
      phase_cnt <= phase_cnt + 4'd1;
    end
  end

  // Address and write data are loaded only on phase entry so they stay flat
  // for the whole half-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else if (state_change) begin
      case (state_next)
        RD_LO: sram_addr <= half_addr(word, 1'b0);
        RD_HI: sram_addr <= half_addr(word, 1'b1);
        WR_LO: begin
          sram_addr   <= half_addr(word, 1'b0);
          sram_dq_out <= write_data[15:0];
        end
        WR_HI: begin
          sram_addr   <= half_addr(word, 1'b1);
          sram_dq_out <= write_data[31:16];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_data   <= '0;
      read_data <= '0;
    end else if (state == RD_LO && last_phase) begin
      lo_data <= sram_dq_in;
    end else if (state == RD_HI && last_phase) begin
      read_data <= {sram_dq_in, lo_data};
    end
`ifdef SRAM_RANGE_CHECK_EN
    else if (state == IDLE && state_next == DONE && !wr_en) begin
      read_data <= '0;
    end
`endif
  end

  // we_n rises on the last cycle of a write phase so data is held across the
  // rising edge; with single-cycle phases there is no room for that.
  always_comb begin
    ready      = 1'b0;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state)
      IDLE: ready = !(rd_en || wr_en);
      DONE: ready = 1'b1;
      WR_LO, WR_HI: begin
        sram_dq_oe = 1'b1;
        sram_we_n  = (HALF_CYCLES == 1) ? 1'b0 : last_phase;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural async SRAM model.
module tb_sram_controller;

  localparam int HC     = 3;
  localparam int FREEZE = 2 * HC + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  logic [15:0] mem [0:1023];

  typedef struct {
    logic [31:0] data;
    int          freeze;
    int          we_low;
    logic [17:0] lo;
    logic [17:0] hi;
    bit          chk_addr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_words [int];
  logic [31:0] last_rd = '0;

  int          errors = 0;
  int          checks = 0;
  int          obs_freeze;
  int          obs_we_low;
  logic [31:0] obs_data;
  logic [17:0] obs_lo;
  logic [17:0] obs_hi;

  sram_controller #(.HALF_CYCLES(HC)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  // Pad resolution: the bus carries controller data while oe is high.
  assign sram_dq_in = sram_dq_oe ? sram_dq_out : mem[sram_addr[9:0]];

  always @(negedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[9:0]] = sram_dq_out;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: computes what one access should look like.
  function automatic void predict(input bit wr, input logic [31:0] addr,
                                  input logic [31:0] data, input bit in_range);
    exp_t        e;
    logic [31:0] off;
    logic [16:0] w;
    off = addr - 32'd1024;
    w   = off[18:2];
    e.chk_addr = in_range;
    e.lo = {w, 1'b0};
    e.hi = {w, 1'b1};
    if (!in_range) begin
      e.freeze = 1;
      e.we_low = 0;
      if (!wr) last_rd = '0;
    end else begin
      e.freeze = FREEZE;
      if (wr) begin
        ref_words[int'(w)] = data;
        e.we_low = 2 * (HC - 1);
      end else begin
        last_rd  = ref_words[int'(w)];
        e.we_low = 0;
      end
    end
    e.data = last_rd;
    sb.push_back(e);
  endfunction

  task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] data, input bit hold);
    @(posedge clk);
    #1;
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    obs_freeze = 0; obs_we_low = 0; obs_lo = '0; obs_hi = '0;
    while (1) begin
      @(negedge clk);
      if (!sram_we_n) obs_we_low++;
      if (ready) break;
      if (obs_freeze == 1) obs_lo = sram_addr;
      if (obs_freeze == HC + 1) obs_hi = sram_addr;
      obs_freeze++;
      if (obs_freeze > 60) begin
        checks++; errors++;
        $display("[TB] FAIL ready_timeout: ready still low after %0d cycles, required by %0d",
                 obs_freeze, FREEZE);
        break;
      end
    end
    obs_data = read_data;
    if (!hold) begin
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b need 1", ready); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_read_data: got %h need 0", read_data); end
    checks++; if (sram_addr !== 18'h0) begin errors++; $display("[TB] FAIL reset_sram_addr: got %h need 0", sram_addr); end
    checks++; if (sram_dq_out !== 16'h0) begin errors++; $display("[TB] FAIL reset_dq_out: got %h need 0", sram_dq_out); end
    checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe: got %b need 0", sram_dq_oe); end
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_we_n: got %b need 1", sram_we_n); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b need 1", ready); end
  endtask

  task automatic test_write_read_basic();
    exp_t e;
    logic [31:0] addr_tab [2] = '{32'd1024, 32'd1024};
    bit          wr_tab   [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      predict(wr_tab[i], addr_tab[i], 32'hDEADBEEF, 1'b1);
      run_access(wr_tab[i], !wr_tab[i], addr_tab[i], 32'hDEADBEEF, 1'b0);
      e = sb.pop_front();
      checks++; if (obs_freeze !== e.freeze) begin errors++; $display("[TB] FAIL basic_freeze[%0d]: got %0d need %0d", i, obs_freeze, e.freeze); end
      checks++; if (obs_data !== e.data) begin errors++; $display("[TB] FAIL basic_read_data[%0d]: got %h need %h", i, obs_data, e.data); end
      checks++; if (obs_we_low !== e.we_low) begin errors++; $display("[TB] FAIL basic_we_low[%0d]: got %0d need %0d", i, obs_we_low, e.we_low); end
      checks++; if (obs_lo !== e.lo || obs_hi !== e.hi) begin errors++; $display("[TB] FAIL basic_addr[%0d]: got %0d,%0d need %0d,%0d", i, obs_lo, obs_hi, e.lo, e.hi); end
      if (i == 0) begin
        checks++; if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin errors++; $display("[TB] FAIL basic_sram_words: got %h,%h need beef,dead", mem[0], mem[1]); end
      end
    end
  endtask

  task automatic test_both_enables();
    exp_t e;
    predict(1'b1, 32'd1024, 32'h12345678, 1'b1);
    run_access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
    e = sb.pop_front();
    checks++; if (obs_freeze !== e.freeze) begin errors++; $display("[TB] FAIL both_freeze: got %0d need %0d", obs_freeze, e.freeze); end
    checks++; if (obs_data !== e.data) begin errors++; $display("[TB] FAIL both_read_data: got %h need %h", obs_data, e.data); end
    checks++; if (obs_we_low !== e.we_low) begin errors++; $display("[TB] FAIL both_we_low: got %0d need %0d", obs_we_low, e.we_low); end
    checks++; if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234) begin errors++; $display("[TB] FAIL both_sram_words: got %h,%h need 5678,1234", mem[0], mem[1]); end
    predict(1'b0, 32'd1024, 32'h0, 1'b1);
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    e = sb.pop_front();
    checks++; if (obs_data !== e.data) begin errors++; $display("[TB] FAIL both_readback: got %h need %h", obs_data, e.data); end
  endtask

  task automatic test_independent_words();
    exp_t e;
    logic [31:0] addr_tab [4] = '{32'd1028, 32'd1032, 32'd1028, 32'd1032};
    logic [31:0] data_tab [4] = '{32'hA1A2B3B4, 32'hC5C6D7D8, 32'h0, 32'h0};
    bit          wr_tab   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      predict(wr_tab[i], addr_tab[i], data_tab[i], 1'b1);
      run_access(wr_tab[i], !wr_tab[i], addr_tab[i], data_tab[i], 1'b0);
      e = sb.pop_front();
      checks++; if (obs_freeze !== e.freeze) begin errors++; $display("[TB] FAIL words_freeze[%0d]: got %0d need %0d", i, obs_freeze, e.freeze); end
      checks++; if (obs_data !== e.data) begin errors++; $display("[TB] FAIL words_read_data[%0d]: got %h need %h", i, obs_data, e.data); end
      checks++; if (obs_we_low !== e.we_low) begin errors++; $display("[TB] FAIL words_we_low[%0d]: got %0d need %0d", i, obs_we_low, e.we_low); end
      checks++; if (obs_lo !== e.lo || obs_hi !== e.hi) begin errors++; $display("[TB] FAIL words_addr[%0d]: got %0d,%0d need %0d,%0d", i, obs_lo, obs_hi, e.lo, e.hi); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   low_cnt;
    logic [31:0] addr_tab [2] = '{32'd1028, 32'd1032};
    for (int i = 0; i < 2; i++) begin
      predict(1'b0, addr_tab[i], 32'h0, 1'b1);
      run_access(1'b0, 1'b1, addr_tab[i], 32'h0, (i == 0));
      e = sb.pop_front();
      checks++; if (obs_freeze !== e.freeze) begin errors++; $display("[TB] FAIL b2b_freeze[%0d]: got %0d need %0d", i, obs_freeze, e.freeze); end
      checks++; if (obs_data !== e.data) begin errors++; $display("[TB] FAIL b2b_read_data[%0d]: got %h need %h", i, obs_data, e.data); end
    end
    low_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (!ready) low_cnt++;
    end
    checks++; if (low_cnt !== 0) begin errors++; $display("[TB] FAIL b2b_spurious: got %0d busy cycles need 0", low_cnt); end
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    @(posedge clk);
    #1;
    wr_en = 1'b1; address = 32'd1040; write_data = 32'h55556666;
    repeat (3) @(negedge clk);
    checks++; if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin errors++; $display("[TB] FAIL midwr_active: got we_n=%b oe=%b need 0,1", sram_we_n, sram_dq_oe); end
    #1 rst = 1'b1;
    #1;
    checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin errors++; $display("[TB] FAIL midwr_async: got we_n=%b oe=%b need 1,0", sram_we_n, sram_dq_oe); end
    wr_en = 1'b0;
    last_rd = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1 || sram_we_n !== 1'b1) begin errors++; $display("[TB] FAIL midwr_idle: got ready=%b we_n=%b need 1,1", ready, sram_we_n); end
    checks++; if (mem[9] !== 16'h0) begin errors++; $display("[TB] FAIL midwr_hi_untouched: got %h need 0", mem[9]); end
    predict(1'b0, 32'd1028, 32'h0, 1'b1);
    run_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    e = sb.pop_front();
    checks++; if (obs_data !== e.data) begin errors++; $display("[TB] FAIL midwr_recover: got %h need %h", obs_data, e.data); end
  endtask

`ifdef SRAM_RANGE_CHECK_EN
  task automatic test_range_check();
    exp_t e;
    logic [31:0] addr_tab [3] = '{32'd512, 32'd512, 32'd1024 + (32'd1 << 19)};
    bit          wr_tab   [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      predict(wr_tab[i], addr_tab[i], 32'hFFFF0000, 1'b0);
      run_access(wr_tab[i], !wr_tab[i], addr_tab[i], 32'hFFFF0000, 1'b0);
      e = sb.pop_front();
      checks++; if (obs_freeze !== e.freeze) begin errors++; $display("[TB] FAIL range_freeze[%0d]: got %0d need %0d", i, obs_freeze, e.freeze); end
      checks++; if (obs_data !== e.data) begin errors++; $display("[TB] FAIL range_read_data[%0d]: got %h need %h", i, obs_data, e.data); end
      checks++; if (obs_we_low !== e.we_low) begin errors++; $display("[TB] FAIL range_we_low[%0d]: got %0d need %0d", i, obs_we_low, e.we_low); end
    end
  endtask
`else
  task automatic test_address_wrap();
    exp_t e;
    logic [31:0] wrap_addr;
    wrap_addr = 32'd1024 + (32'd1 << 19);
    predict(1'b1, wrap_addr, 32'h0BADF00D, 1'b1);
    run_access(1'b1, 1'b0, wrap_addr, 32'h0BADF00D, 1'b0);
    e = sb.pop_front();
    checks++; if (obs_lo !== e.lo || obs_hi !== e.hi) begin errors++; $display("[TB] FAIL wrap_addr: got %0d,%0d need %0d,%0d", obs_lo, obs_hi, e.lo, e.hi); end
    predict(1'b0, 32'd1024, 32'h0, 1'b1);
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    e = sb.pop_front();
    checks++; if (obs_data !== e.data) begin errors++; $display("[TB] FAIL wrap_readback: got %h need %h", obs_data, e.data); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    test_reset();
    test_write_read_basic();
    test_both_enables();
    test_independent_words();
    test_back_to_back();
    test_reset_mid_write();
`ifdef SRAM_RANGE_CHECK_EN
    test_range_check();
`else
    test_address_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Data-memory responder for the 5-stage pipeline's MEM stage. Accepts one 32-bit read or write request at a time and serves it as two 16-bit accesses to the external asynchronous SRAM. Drops `ready` while busy so the pipeline freezes with the request held stable. Replaces the single-cycle data memory behind the MEM stage.

## Interface
- `HALF_CYCLES`, 3: cycles each 16-bit half-access holds address/controls (legal range 1–15).
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `clk`  input  1  the single clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `wr_en`  input  1  write request from MEM stage, level, held until `ready`.
- `rd_en`  input  1  read request from MEM stage, level, held until `ready`.
- `address`  input  32  byte address from ALU result.
- `write_data`  input  32  store data (Val_Rm).
- `read_data`  output  32  load result, valid in the `ready` cycle that completes a read.
- `ready`  output  1  low = freeze pipeline.
- `sram_addr`  output  18  SRAM half-word address.
- `sram_dq_out`  output  16  data driven to SRAM.
- `sram_dq_oe`  output  1  tristate enable for `sram_dq_out`; bench/pad resolves the inout.
- `sram_dq_in`  input  16  data returned by SRAM.
- `sram_we_n`  output  1  SRAM write strobe, active-low.

## Operation
- Address map: word index `w = (address - BASE_ADDR) >> 2`. Low half goes to `sram_addr = {w[16:0],1'b0}`; high half goes to `{w[16:0],1'b1}`. Bits [1:0] are ignored.
- Data split: `write_data[15:0]` goes to the low half and `[31:16]` to the high half. `read_data = {hi,lo}`.
- FSM states:
  - IDLE. `rd_en` moves to RD_LO; `wr_en` moves to WR_LO. If both are high, `wr_en` wins.
  - RD_LO then RD_HI.
  - WR_LO then WR_HI.
  - DONE.
- Each of RD_LO/RD_HI/WR_LO/WR_HI lasts exactly `HALF_CYCLES` cycles, counted by a 4-bit phase counter that clears on every state change.
- Reads: `sram_we_n=1`, `sram_dq_oe=0`. `sram_dq_in` is captured into the lo/hi register on the last cycle of its phase.
- Writes: `sram_dq_oe=1` throughout WR_*. `sram_we_n=0` on every cycle of the phase except the last, where it is 1. This gives data hold as `we_n` rises. When `HALF_CYCLES=1`, `we_n` is low for that one cycle.
- DONE lasts one cycle, then goes to IDLE unconditionally. The request is still asserted during DONE and must not restart an access.
- `ready` (combinational): 1 in DONE. 1 in IDLE when `rd_en|wr_en` is 0. 0 otherwise, including IDLE with a request present (same-cycle freeze).
- `read_data` is registered. It holds its last value until the next read completes. Writes never change it.

## Timing
- Reset values: state IDLE, counter 0, `read_data=0`, `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`, `sram_we_n=1`, `ready=1` (no request).
- Latency: with the request first seen in IDLE at cycle 0, `ready` is 0 for cycles 0 .. 2·HALF_CYCLES and 1 at cycle 2·HALF_CYCLES+1 (DONE). This is 2·HALF_CYCLES+1 freeze cycles; the default is 7.
- Back-to-back requests: the pipeline advances at DONE. A new request seen in the following IDLE cycle starts immediately, so there is no idle bubble beyond that one cycle.
- Reset during an access: on assertion, `sram_we_n` goes to 1 and `sram_dq_oe` to 0 asynchronously. The partial write is abandoned and the FSM is in IDLE.
- `sram_addr` and `sram_dq_out` are registered. They change only at phase entry, never mid-phase.

## Configuration
- `SRAM_RANGE_CHECK_EN` defined:
  - An address below `BASE_ADDR`, or with `w ≥ 2^17`, skips the SRAM phases and goes IDLE → DONE.
  - `ready` drops for exactly 1 cycle.
  - Reads return `read_data = 0`. Writes are discarded and `sram_we_n` stays 1.
- Not defined: no check. The address is truncated to 17 word bits and wraps.

## Structure
- Shared package `sram_pkg`:
  - state enum (IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE);
  - `SRAM_ADDR_W=18`, `SRAM_DATA_W=16`;
  - default `BASE_ADDR`.
- Single RTL module with no sub-module. The bench provides a behavioural `sram_model` that resolves the inout.

## Test plan
- Write 0xDEADBEEF to 1024, then read 1024. Required response:
  - SRAM word 0 = 0xBEEF, word 1 = 0xDEAD;
  - `read_data=0xDEADBEEF`;
  - `ready` low 7 cycles per access.
- Write then read at 1028 and 1032. Required: `sram_addr` sequences 2,3 and 4,5; data is independent per word.
- Assert `rd_en` and `wr_en` together at 1024 with data 0x12345678. Required: a write occurs and `read_data` is unchanged.
- Assert `rst` at cycle 2 of WR_LO. Required: `sram_we_n=1` and `oe=0` immediately; after release, IDLE with `ready=1`.
- Two back-to-back reads with request held through DONE. Required: exactly two accesses and no spurious third.
- With `SRAM_RANGE_CHECK_EN`, read at address 512. Required: `ready` low 1 cycle, `read_data=0`, `sram_we_n` stays 1.
